mem_port_arbiter: RTL and testbench

- Shares one 64-bit single-ported memory between the core's instruction-fetch side and its load/store side.
- Sequences each access with a valid/ready handshake toward memory and an ack pulse toward the core; the core stalls while a request is unacknowledged.
- Holds a one-entry fetch line buffer, so two sequential 32-bit instructions cost one memory access.
- Sits between the RISC-V core and the unified memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_fetch_line_buf.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, widths and helpers for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_AW        = 30;
    localparam int unsigned DW_AW          = 29;
    localparam int unsigned DATA_W         = 64;
    localparam int unsigned INSN_W         = 32;
    localparam int unsigned WDT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_D_ACC = 2'd1,
        ST_I_ACC = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              wen;
        logic [DW_AW-1:0]  addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Picks one instruction out of a doubleword using byte-address bit 2.
    function automatic logic [INSN_W-1:0] sel_insn(input logic [DATA_W-1:0] line, input logic hi);
        return hi ? line[DATA_W-1:INSN_W] : line[INSN_W-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_fetch_line_buf.sv
// One-entry fetch line buffer: valid/tag/data with hit compare, fill and tagged invalidate.
module mem_port_arbiter_fetch_line_buf
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW_AW-1:0]  lookup_tag_i,
    output logic              hit_c_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              fill_i,
    input  logic [DW_AW-1:0]  fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              inval_i,
    input  logic [DW_AW-1:0]  inval_tag_i
);

    logic              valid_q, valid_d;
    logic [DW_AW-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Fill wins over invalidate; both never happen in the same cycle anyway.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inval_i && (inval_tag_i == tag_q)) begin
            valid_d = 1'b0;
        end
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_c_o = valid_q && (lookup_tag_i == tag_q);
    assign data_o  = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported 64-bit memory between instruction fetch and load/store,
// with a one-line fetch buffer and a mem_ready watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit          LBUF_EN    = 1'b1,
    parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF,
    parameter int unsigned WDT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req,
    input  logic [WORD_AW-1:0] i_addr,
    output logic               i_ack,
    output logic [INSN_W-1:0]  i_rdata,
    input  logic               d_req,
    input  logic               d_wen,
    input  logic [WORD_AW-1:0] d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic               d_ack,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               mem_cen,
    output logic               mem_wen,
    output logic [DW_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               err
);

    localparam bit               WDT_ON   = (WDT_CYCLES != 0);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              ihi_q, ihi_d;
    logic              cen_q, cen_d;
    logic              err_q, err_d;
    logic [WDT_W-1:0]  wdt_q, wdt_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [INSN_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              lbuf_hit_c, lbuf_fill_c, lbuf_inval_c;
    logic [DATA_W-1:0] lbuf_data;
    logic              unused_addr_bit;

    // Doubleword accesses: byte-address bit 2 of a data address carries no meaning.
    assign unused_addr_bit = d_addr[0];

    mem_port_arbiter_fetch_line_buf u_fetch_line_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_tag_i (i_addr[WORD_AW-1:1]),
        .hit_c_o      (lbuf_hit_c),
        .data_o       (lbuf_data),
        .fill_i       (LBUF_EN && lbuf_fill_c),
        .fill_tag_i   (req_q.addr),
        .fill_data_i  (mem_rdata),
        .inval_i      (lbuf_inval_c),
        .inval_tag_i  (req_q.addr)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        ihi_d        = ihi_q;
        cen_d        = cen_q;
        err_d        = err_q;
        wdt_d        = wdt_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        lbuf_fill_c  = 1'b0;
        lbuf_inval_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Data always beats fetch; a buffered fetch costs no memory cycle.
                if (d_req) begin
                    state_d     = ST_D_ACC;
                    req_d.wen   = d_wen;
                    req_d.addr  = d_addr[WORD_AW-1:1];
                    req_d.wdata = d_wdata;
                    cen_d       = 1'b1;
                    wdt_d       = '0;
                end else if (i_req && LBUF_EN && lbuf_hit_c) begin
                    state_d   = ST_RESP;
                    i_ack_d   = 1'b1;
                    i_rdata_d = sel_insn(lbuf_data, i_addr[0]);
                end else if (i_req) begin
                    state_d     = ST_I_ACC;
                    req_d.wen   = 1'b0;
                    req_d.addr  = i_addr[WORD_AW-1:1];
                    req_d.wdata = '0;
                    ihi_d       = i_addr[0];
                    cen_d       = 1'b1;
                    wdt_d       = '0;
                end
            end
            ST_D_ACC, ST_I_ACC: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    cen_d   = 1'b0;
                    if (state_q == ST_D_ACC) begin
                        d_ack_d      = 1'b1;
                        lbuf_inval_c = req_q.wen;
                        if (!req_q.wen) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_ack_d     = 1'b1;
                        i_rdata_d   = sel_insn(mem_rdata, ihi_q);
                        lbuf_fill_c = 1'b1;
                    end
                end else if (WDT_ON && (wdt_q == WDT_LAST)) begin
                    // Memory never answered: abort and complete with zero data.
                    state_d = ST_RESP;
                    cen_d   = 1'b0;
                    err_d   = 1'b1;
                    wdt_d   = wdt_q + WDT_W'(1);
                    if (state_q == ST_D_ACC) begin
                        d_ack_d = 1'b1;
                        if (!req_q.wen) begin
                            d_rdata_d = '0;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = '0;
                    end
                end else if (WDT_ON) begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            ihi_q     <= 1'b0;
            cen_q     <= 1'b0;
            err_q     <= 1'b0;
            wdt_q     <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ihi_q     <= ihi_d;
            cen_q     <= cen_d;
            err_q     <= err_d;
            wdt_q     <= wdt_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_cen   = cen_q;
    assign mem_wen   = req_q.wen;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboarded acks plus per-scenario timing checks.
module tb_mem_port_arbiter;

    localparam logic [63:0] LOAD_VAL  = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] STORE_VAL = 64'hDEAD_BEEF_CAFE_F00D;

    typedef struct {
        bit          dport;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wen, mem_ready;
    logic [29:0] i_addr, d_addr;
    logic [63:0] d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_cen, mem_wen, err;
    logic [31:0] i_rdata;
    logic [63:0] d_rdata, mem_wdata;
    logic [28:0] mem_addr;

    logic        i_req_nb, d_req_nb, d_wen_nb, mem_ready_nb;
    logic [29:0] i_addr_nb, d_addr_nb;
    logic [63:0] d_wdata_nb, mem_rdata_nb;
    logic        i_ack_nb, d_ack_nb, mem_cen_nb, mem_wen_nb, err_nb;
    logic [31:0] i_rdata_nb;
    logic [63:0] d_rdata_nb, mem_wdata_nb;
    logic [28:0] mem_addr_nb;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    exp_t        sb_q[$];

    int          mem_lat  = 1;
    bit          mem_hang = 1'b0;
    logic [63:0] mem_val  = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LBUF_EN(1'b1), .WDT_CYCLES(4), .WDT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    mem_port_arbiter #(.LBUF_EN(1'b0), .WDT_CYCLES(4), .WDT_W(8)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req_nb), .i_addr(i_addr_nb), .i_ack(i_ack_nb), .i_rdata(i_rdata_nb),
        .d_req(d_req_nb), .d_wen(d_wen_nb), .d_addr(d_addr_nb), .d_wdata(d_wdata_nb),
        .d_ack(d_ack_nb), .d_rdata(d_rdata_nb),
        .mem_cen(mem_cen_nb), .mem_wen(mem_wen_nb), .mem_addr(mem_addr_nb), .mem_wdata(mem_wdata_nb),
        .mem_rdata(mem_rdata_nb), .mem_ready(mem_ready_nb), .err(err_nb)
    );

    // Memory model for the main instance: answers in the mem_lat-th cycle of mem_cen.
    initial begin : mem_model
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (rst_n === 1'b1 && mem_cen === 1'b1) begin
                cnt++;
                if (!mem_hang && cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_val;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every ack of the main instance must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && (i_ack === 1'b1 || d_ack === 1'b1)) begin
            vec_cnt++;
            if (sb_q.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_unexpected_ack: i_ack=%b d_ack=%b, required no ack", i_ack, d_ack);
            end else begin
                e = sb_q.pop_front();
                if (e.dport) begin
                    if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== e.data) begin
                        err_cnt++;
                        $display("FAIL sb_data_ack: d_ack=%b i_ack=%b d_rdata=%h, required d_ack=1 d_rdata=%h",
                                 d_ack, i_ack, d_rdata, e.data);
                    end
                end else begin
                    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== e.data[31:0]) begin
                        err_cnt++;
                        $display("FAIL sb_fetch_ack: i_ack=%b d_ack=%b i_rdata=%h, required i_ack=1 i_rdata=%h",
                                 i_ack, d_ack, i_rdata, e.data[31:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit dport, input logic [63:0] data);
        exp_t e;
        e.dport = dport;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    // Returns cycles from the request to the ack, or -1 if none arrives in budget.
    task automatic wait_ack(input bit dport, input int start, output int cyc);
        cyc = start;
        while (cyc < 20) begin
            step();
            cyc++;
            if ((dport ? d_ack : i_ack) === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {i_req, d_req, d_wen, i_req_nb, d_req_nb, d_wen_nb, mem_ready_nb} = '0;
        {i_addr, d_addr, i_addr_nb, d_addr_nb} = '0;
        {d_wdata, d_wdata_nb, mem_rdata_nb} = '0;
        repeat (3) step();
        vec_cnt++;
        if ({i_ack, d_ack, mem_cen, mem_wen, err, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: ack=%b%b cen=%b wen=%b err=%b irdata=%h drdata=%h addr=%h wdata=%h, required all 0",
                     i_ack, d_ack, mem_cen, mem_wen, err, i_rdata, d_rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch_miss_hit();
        int cyc;
        mem_lat = 3;
        mem_val = 64'h1111_2222_3333_4444;
        push_exp(1'b0, 64'h1111_2222);
        i_addr = 30'h1;
        i_req  = 1'b1;
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1 || mem_addr !== 29'h0 || mem_wen !== 1'b0) begin
            err_cnt++;
            $display("FAIL miss_mem_req: cen=%b addr=%h wen=%b, required cen=1 addr=0 wen=0", mem_cen, mem_addr, mem_wen);
        end
        wait_ack(1'b0, 1, cyc);
        i_req = 1'b0;
        vec_cnt++;
        if (cyc !== 4) begin
            err_cnt++;
            $display("FAIL miss_latency: got %0d cycles, required 4", cyc);
        end
        step();
        vec_cnt++;
        if (i_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL ack_one_cycle: i_ack=%b, required 0", i_ack);
        end
        push_exp(1'b0, 64'h3333_4444);
        i_addr = 30'h0;
        i_req  = 1'b1;
        step();
        vec_cnt++;
        if (i_ack !== 1'b1 || mem_cen !== 1'b0) begin
            err_cnt++;
            $display("FAIL hit_latency: i_ack=%b mem_cen=%b, required i_ack=1 mem_cen=0", i_ack, mem_cen);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_data_priority();
        int cyc;
        mem_lat = 1;
        mem_val = LOAD_VAL;
        push_exp(1'b1, LOAD_VAL);
        d_addr = 30'h10;
        d_wen  = 1'b0;
        d_req  = 1'b1;
        i_addr = 30'h40;
        i_req  = 1'b1;
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1 || mem_addr !== 29'h8 || mem_wen !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_data_first: cen=%b addr=%h wen=%b, required cen=1 addr=8 wen=0", mem_cen, mem_addr, mem_wen);
        end
        wait_ack(1'b1, 1, cyc);
        d_req = 1'b0;
        vec_cnt++;
        if (cyc !== 2 || i_ack !== 1'b0 || mem_cen !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_load_ack: cycles=%0d i_ack=%b cen=%b, required 2 0 0", cyc, i_ack, mem_cen);
        end
        mem_val = 64'h0BAD_F00D_1234_5678;
        push_exp(1'b0, 64'h1234_5678);
        step();
        vec_cnt++;
        if (mem_cen !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_resp_idle: cen=%b, required 0", mem_cen);
        end
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1 || mem_addr !== 29'h20) begin
            err_cnt++;
            $display("FAIL prio_fetch_start: cen=%b addr=%h, required cen=1 addr=20", mem_cen, mem_addr);
        end
        wait_ack(1'b0, 0, cyc);
        i_req = 1'b0;
        vec_cnt++;
        if (cyc !== 1) begin
            err_cnt++;
            $display("FAIL prio_fetch_ack: got %0d cycles, required 1", cyc);
        end
        step();
    endtask

    task automatic test_store_invalidate();
        int cyc;
        push_exp(1'b0, 64'h0BAD_F00D);
        i_addr = 30'h41;
        i_req  = 1'b1;
        step();
        vec_cnt++;
        if (i_ack !== 1'b1 || mem_cen !== 1'b0) begin
            err_cnt++;
            $display("FAIL inv_prehit: i_ack=%b cen=%b, required i_ack=1 cen=0", i_ack, mem_cen);
        end
        i_req = 1'b0;
        step();
        mem_lat = 1;
        push_exp(1'b1, LOAD_VAL);
        d_addr  = 30'h40;
        d_wen   = 1'b1;
        d_wdata = STORE_VAL;
        d_req   = 1'b1;
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 29'h20 || mem_wdata !== STORE_VAL) begin
            err_cnt++;
            $display("FAIL store_req: cen=%b wen=%b addr=%h wdata=%h, required 1 1 20 %h",
                     mem_cen, mem_wen, mem_addr, mem_wdata, STORE_VAL);
        end
        wait_ack(1'b1, 1, cyc);
        d_req = 1'b0;
        d_wen = 1'b0;
        vec_cnt++;
        if (cyc !== 2) begin
            err_cnt++;
            $display("FAIL store_latency: got %0d cycles, required 2", cyc);
        end
        step();
        mem_lat = 2;
        mem_val = STORE_VAL;
        push_exp(1'b0, 64'hDEAD_BEEF);
        i_addr = 30'h41;
        i_req  = 1'b1;
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1 || mem_wen !== 1'b0) begin
            err_cnt++;
            $display("FAIL inv_refetch: cen=%b wen=%b, required cen=1 wen=0", mem_cen, mem_wen);
        end
        wait_ack(1'b0, 1, cyc);
        i_req = 1'b0;
        vec_cnt++;
        if (cyc !== 3) begin
            err_cnt++;
            $display("FAIL inv_refetch_latency: got %0d cycles, required 3", cyc);
        end
        step();
    endtask

    task automatic test_watchdog();
        int cyc, cen_hi;
        mem_hang = 1'b1;
        push_exp(1'b1, 64'h0);
        d_addr = 30'h100;
        d_wen  = 1'b0;
        d_req  = 1'b1;
        cyc    = 0;
        cen_hi = 0;
        while (cyc < 20) begin
            step();
            cyc++;
            if (cyc == 1) begin
                vec_cnt++;
                if (err !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL wdt_err_early: err=%b, required 0", err);
                end
            end
            if (mem_cen === 1'b1) cen_hi++;
            if (d_ack === 1'b1) break;
        end
        d_req = 1'b0;
        vec_cnt++;
        if (cyc !== 5 || cen_hi !== 4 || err !== 1'b1 || mem_cen !== 1'b0) begin
            err_cnt++;
            $display("FAIL wdt_abort: ack_cycles=%0d cen_cycles=%0d err=%b cen=%b, required 5 4 1 0",
                     cyc, cen_hi, err, mem_cen);
        end
        mem_hang = 1'b0;
        step();
        mem_lat = 2;
        mem_val = 64'h7777_6666_5555_4444;
        push_exp(1'b0, 64'h7777_6666);
        i_addr = 30'h81;
        i_req  = 1'b1;
        wait_ack(1'b0, 0, cyc);
        i_req = 1'b0;
        vec_cnt++;
        if (cyc !== 3 || err !== 1'b1) begin
            err_cnt++;
            $display("FAIL wdt_after: cycles=%0d err=%b, required 3 1", cyc, err);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        int cyc;
        mem_hang = 1'b1;
        d_addr = 30'h200;
        d_wen  = 1'b0;
        d_req  = 1'b1;
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_mid_start: cen=%b, required 1", mem_cen);
        end
        step();
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        vec_cnt++;
        if (mem_cen !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_async: cen=%b d_ack=%b err=%b, required 0 0 0", mem_cen, d_ack, err);
        end
        repeat (2) step();
        mem_hang = 1'b0;
        rst_n    = 1'b1;
        step();
        mem_lat = 1;
        mem_val = 64'h9999_8888_0000_1111;
        push_exp(1'b0, 64'h9999_8888);
        i_addr = 30'h81;
        i_req  = 1'b1;
        step();
        vec_cnt++;
        if (mem_cen !== 1'b1 || i_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_buf_miss: cen=%b i_ack=%b, required cen=1 i_ack=0", mem_cen, i_ack);
        end
        wait_ack(1'b0, 1, cyc);
        i_req = 1'b0;
        vec_cnt++;
        if (cyc !== 2) begin
            err_cnt++;
            $display("FAIL rst_refetch_latency: got %0d cycles, required 2", cyc);
        end
        step();
    endtask

    task automatic test_no_line_buf();
        logic [63:0] line [2];
        logic [31:0] want [2];
        line[0] = 64'h1111_0000_2222_0000;
        line[1] = 64'h3333_4444_5555_6666;
        want[0] = 32'h1111_0000;
        want[1] = 32'h5555_6666;
        for (int k = 0; k < 2; k++) begin
            mem_rdata_nb = line[k];
            i_addr_nb    = (k == 0) ? 30'h3 : 30'h2;
            i_req_nb     = 1'b1;
            step();
            vec_cnt++;
            if (mem_cen_nb !== 1'b1 || mem_addr_nb !== 29'h1 || i_ack_nb !== 1'b0) begin
                err_cnt++;
                $display("FAIL nobuf_access%0d: cen=%b addr=%h i_ack=%b, required 1 1 0",
                         k, mem_cen_nb, mem_addr_nb, i_ack_nb);
            end
            mem_ready_nb = 1'b1;
            step();
            mem_ready_nb = 1'b0;
            i_req_nb     = 1'b0;
            vec_cnt++;
            if (i_ack_nb !== 1'b1 || i_rdata_nb !== want[k] || mem_cen_nb !== 1'b0) begin
                err_cnt++;
                $display("FAIL nobuf_ack%0d: i_ack=%b i_rdata=%h cen=%b, required 1 %h 0",
                         k, i_ack_nb, i_rdata_nb, mem_cen_nb, want[k]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_miss_hit();
        test_data_priority();
        test_store_invalidate();
        test_watchdog();
        test_reset_mid_access();
        test_no_line_buf();
        step();
        vec_cnt++;
        if (sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL sb_leftover: %0d expected acks never arrived, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
